// File: rtl/macroblock_block_sequencer_pkg.sv
// Shared types and constants for the macroblock block sequencer: FSM state
// encodings, DC predictor reset base and the block-to-component map.
package macroblock_block_sequencer_pkg;

    localparam int DC_WIDTH   = 12;
    localparam int NUM_BLOCKS = 6;

    localparam logic [DC_WIDTH-1:0] DC_RESET_BASE = 12'h080;

    localparam logic [2:0] FIRST_CHROMA_BLOCK = 3'd4;
    localparam logic [2:0] CB_BLOCK           = 3'd4;
    localparam logic [2:0] CR_BLOCK           = 3'd5;
    localparam logic [2:0] LAST_BLOCK         = 3'd5;
    localparam logic [5:0] CBP_ALL_CODED      = 6'h3F;

    typedef enum logic [2:0] {
        MB_SEQ_IDLE  = 3'd0,
        MB_SEQ_ISSUE = 3'd1,
        MB_SEQ_ARM   = 3'd2,
        MB_SEQ_WAIT  = 3'd3,
        MB_SEQ_DONE  = 3'd4
    } mb_seq_state_e;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } dc_comp_e;

    function automatic dc_comp_e block_component(input logic [2:0] idx);
        dc_comp_e comp;
        case (idx)
            CB_BLOCK: comp = COMP_CB;
            CR_BLOCK: comp = COMP_CR;
            default:  comp = COMP_Y;
        endcase
        return comp;
    endfunction

    // 128 << precision: 0x080, 0x100, 0x200, 0x400.
    function automatic logic [DC_WIDTH-1:0] dc_reset_value(input logic [1:0] precision);
        return DC_RESET_BASE << precision;
    endfunction

endpackage

// File: rtl/macroblock_block_sequencer_if.sv
// Bundle of the macroblock-level and block-decoder handshake signals.
// Start_Macroblock_I and Start_Block_Decode_O are single-cycle pulses;
// Done_Block_Decode_I is a level that is high whenever the block decoder is idle.
interface macroblock_block_sequencer_if;
    import macroblock_block_sequencer_pkg::*;

    logic                Start_Macroblock_I;
    logic                Macroblock_Intra_I;
    logic [5:0]          Coded_Block_Pattern_I;
    logic [1:0]          Intra_DC_Precision_I;
    logic                Reset_DC_Predict_I;
    logic                Busy_O;
    logic                Done_Macroblock_O;
    logic                Start_Block_Decode_O;
    logic                Done_Block_Decode_I;
    logic                Pattern_Code_O;
    logic                Luma_Chroma_Sel_O;
    logic                Macroblock_Intra_O;
    logic [2:0]          Block_Index_O;
    logic [DC_WIDTH-1:0] DC_predict_O;
    logic [DC_WIDTH-1:0] New_DC_predict_I;
    logic                Update_DC_predict_I;
    mb_seq_state_e       State_O;

    modport slave (
        input  Start_Macroblock_I, Macroblock_Intra_I, Coded_Block_Pattern_I,
               Intra_DC_Precision_I, Reset_DC_Predict_I, Done_Block_Decode_I,
               New_DC_predict_I, Update_DC_predict_I,
        output Busy_O, Done_Macroblock_O, Start_Block_Decode_O, Pattern_Code_O,
               Luma_Chroma_Sel_O, Macroblock_Intra_O, Block_Index_O, DC_predict_O,
               State_O
    );

    modport master (
        output Start_Macroblock_I, Macroblock_Intra_I, Coded_Block_Pattern_I,
               Intra_DC_Precision_I, Reset_DC_Predict_I, Done_Block_Decode_I,
               New_DC_predict_I, Update_DC_predict_I,
        input  Busy_O, Done_Macroblock_O, Start_Block_Decode_O, Pattern_Code_O,
               Luma_Chroma_Sel_O, Macroblock_Intra_O, Block_Index_O, DC_predict_O,
               State_O
    );

endinterface

// File: rtl/macroblock_block_sequencer_dc_predictor_bank.sv
// Y/Cb/Cr DC predictor registers with bulk reset, per-component update and
// a combinational read mux selected by the current block index.
module dc_predictor_bank
    import macroblock_block_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          block_index_i,
    input  logic [1:0]          precision_i,
    input  logic                reset_all_i,
    input  logic                update_i,
    input  logic [DC_WIDTH-1:0] new_dc_i,
    output logic [DC_WIDTH-1:0] dc_predict_o
);

    logic [DC_WIDTH-1:0] y_q, y_d;
    logic [DC_WIDTH-1:0] cb_q, cb_d;
    logic [DC_WIDTH-1:0] cr_q, cr_d;

    // Bulk reset wins over an update landing on the same edge.
    always_comb begin
        y_d  = y_q;
        cb_d = cb_q;
        cr_d = cr_q;
        if (reset_all_i) begin
            y_d  = dc_reset_value(precision_i);
            cb_d = dc_reset_value(precision_i);
            cr_d = dc_reset_value(precision_i);
        end else if (update_i) begin
            case (block_component(block_index_i))
                COMP_CB: cb_d = new_dc_i;
                COMP_CR: cr_d = new_dc_i;
                default: y_d  = new_dc_i;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            y_q  <= DC_RESET_BASE;
            cb_q <= DC_RESET_BASE;
            cr_q <= DC_RESET_BASE;
        end else begin
            y_q  <= y_d;
            cb_q <= cb_d;
            cr_q <= cr_d;
        end
    end

    always_comb begin
        case (block_component(block_index_i))
            COMP_CB: dc_predict_o = cb_q;
            COMP_CR: dc_predict_o = cr_q;
            default: dc_predict_o = y_q;
        endcase
    end

endmodule

// File: rtl/macroblock_block_sequencer.sv
// Walks the six 4:2:0 blocks of a macroblock, handing each to the block
// decoder with a start pulse and waiting for it to return to idle.
module macroblock_block_sequencer
    import macroblock_block_sequencer_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    macroblock_block_sequencer_if.slave bus
);

    mb_seq_state_e state_q, state_d;
    logic [2:0]    index_q, index_d;
    logic [5:0]    cbp_q, cbp_d;
    logic          intra_q, intra_d;
    logic          start_accept;
    logic          reset_all;

    assign start_accept = (state_q == MB_SEQ_IDLE) && bus.Start_Macroblock_I;
    // Non-intra macroblocks restart DC prediction from the precision value.
    assign reset_all    = bus.Reset_DC_Predict_I || (start_accept && !bus.Macroblock_Intra_I);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MB_SEQ_IDLE;
            index_q <= 3'd0;
            cbp_q   <= 6'd0;
            intra_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cbp_q   <= cbp_d;
            intra_q <= intra_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cbp_d   = cbp_q;
        intra_d = intra_q;
        case (state_q)
            MB_SEQ_IDLE: begin
                if (bus.Start_Macroblock_I) begin
                    cbp_d   = bus.Macroblock_Intra_I ? CBP_ALL_CODED : bus.Coded_Block_Pattern_I;
                    intra_d = bus.Macroblock_Intra_I;
                    index_d = 3'd0;
                    state_d = MB_SEQ_ISSUE;
                end
            end
            MB_SEQ_ISSUE: state_d = MB_SEQ_ARM;
            // Done is still high from the decoder's previous idle period here.
            MB_SEQ_ARM:   state_d = MB_SEQ_WAIT;
            MB_SEQ_WAIT: begin
                if (bus.Done_Block_Decode_I) begin
                    if (index_q == LAST_BLOCK) begin
                        state_d = MB_SEQ_DONE;
                    end else begin
                        index_d = index_q + 3'd1;
                        state_d = MB_SEQ_ISSUE;
                    end
                end
            end
            MB_SEQ_DONE:  state_d = MB_SEQ_IDLE;
            default:      state_d = MB_SEQ_IDLE;
        endcase
    end

    assign bus.Busy_O               = (state_q == MB_SEQ_ISSUE) || (state_q == MB_SEQ_ARM) ||
                                      (state_q == MB_SEQ_WAIT);
    assign bus.Done_Macroblock_O    = (state_q == MB_SEQ_DONE);
    assign bus.Start_Block_Decode_O = (state_q == MB_SEQ_ISSUE);
    assign bus.Pattern_Code_O       = cbp_q[LAST_BLOCK - index_q];
    assign bus.Luma_Chroma_Sel_O    = (index_q >= FIRST_CHROMA_BLOCK);
    assign bus.Macroblock_Intra_O   = intra_q;
    assign bus.Block_Index_O        = index_q;
    assign bus.State_O              = state_q;

    dc_predictor_bank u_dc_bank (
        .clock         (clock),
        .reset         (reset),
        .block_index_i (index_q),
        .precision_i   (bus.Intra_DC_Precision_I),
        .reset_all_i   (reset_all),
        .update_i      (bus.Update_DC_predict_I),
        .new_dc_i      (bus.New_DC_predict_I),
        .dc_predict_o  (bus.DC_predict_O)
    );

endmodule
